// File: rtl/bus_arb_pkg.sv
// Shared types for the Sysbus I/D arbiter.
// Arbiter states, owner encoding and the default burst length.
package bus_arb_pkg;

  localparam int DEF_BEATS = 8;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    WDATA,
    RESP
  } arb_state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } arb_owner_t;

endpackage

// File: rtl/bus_arbiter_rr_arb2.sv
// Two-way round-robin pick between the I and D requesters.
// The remembered winner only moves when a transaction completes.
module rr_arb2
  import bus_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       req_i,
  input  logic       req_d,
  input  logic       done,
  input  arb_owner_t done_owner,
  output arb_owner_t grant
);

  arb_owner_t last;

  always_comb begin
    grant = OWN_I;
    unique case (1'b1)
      (req_i && req_d):
        grant = (last == OWN_I) ? OWN_D : OWN_I;
      (req_d && !req_i):
        grant = OWN_D;
      default:
        grant = OWN_I;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last <= OWN_I;
    end else if (done) begin
      last <= done_owner;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Serializes I-fetch and D-memory transactions onto one Sysbus port.
// Address beat, optional write burst, then tag-matched read response.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int BEATS          = DEF_BEATS
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_req_valid,
  input  logic [BUS_DATA_WIDTH-1:0] i_req_addr,
  input  logic [BUS_TAG_WIDTH-1:0]  i_req_tag,
  output logic                      i_req_ready,
  output logic                      i_resp_valid,
  output logic [BUS_DATA_WIDTH-1:0] i_resp_data,
  output logic                      i_resp_last,
  input  logic                      d_req_valid,
  input  logic [BUS_DATA_WIDTH-1:0] d_req_addr,
  input  logic [BUS_TAG_WIDTH-1:0]  d_req_tag,
  input  logic                      d_req_write,
  input  logic [BUS_DATA_WIDTH-1:0] d_wdata,
  output logic                      d_req_ready,
  output logic                      d_wdata_ready,
  output logic                      d_resp_valid,
  output logic [BUS_DATA_WIDTH-1:0] d_resp_data,
  output logic                      d_resp_last,
  output logic                      bus_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_reqack,
  input  logic                      bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  output logic                      bus_respack
);

  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  arb_state_t state, state_n;
  arb_owner_t owner, grant;
  logic                      write_q;
  logic [BUS_DATA_WIDTH-1:0] addr_q;
  logic [BUS_TAG_WIDTH-1:0]  tag_q;
  logic [CW-1:0]             cnt;

  logic any_req, tag_hit;
  logic addr_done, wbeat, rbeat, rlast, done;

  assign any_req = i_req_valid || d_req_valid;
  assign tag_hit = bus_respcyc && (bus_resptag == tag_q);

  rr_arb2 u_rr (
    .clk        (clk),
    .reset      (reset),
    .req_i      (i_req_valid),
    .req_d      (d_req_valid),
    .done       (done),
    .done_owner (owner),
    .grant      (grant)
  );

  always_comb begin
    state_n     = state;
    bus_reqcyc  = 1'b0;
    bus_req     = '0;
    bus_respack = 1'b0;
    addr_done   = 1'b0;
    wbeat       = 1'b0;
    rbeat       = 1'b0;
    rlast       = 1'b0;
    done        = 1'b0;
    unique case (state)
      IDLE: begin
        // stale beats from an abandoned burst are sunk here
        bus_respack = bus_respcyc;
        if (any_req) state_n = ADDR;
      end
      ADDR: begin
        bus_reqcyc = 1'b1;
        bus_req    = addr_q;
        if (bus_reqack) begin
          addr_done = 1'b1;
          state_n   = write_q ? WDATA : RESP;
        end
      end
      WDATA: begin
        bus_reqcyc = 1'b1;
        bus_req    = d_wdata;
        if (bus_reqack) begin
          wbeat = 1'b1;
          if (cnt == LAST_BEAT) begin
            done    = 1'b1;
            state_n = IDLE;
          end
        end
      end
      RESP: begin
        bus_respack = bus_respcyc;
        if (tag_hit) begin
          rbeat = 1'b1;
          if (cnt == LAST_BEAT) begin
            rlast   = 1'b1;
            done    = 1'b1;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus_reqtag    = tag_q;
  assign i_resp_data   = bus_resp;
  assign d_resp_data   = bus_resp;
  assign i_req_ready   = !reset && addr_done && (owner == OWN_I);
  assign d_req_ready   = !reset && addr_done && (owner == OWN_D);
  assign d_wdata_ready = !reset && wbeat;
  assign i_resp_valid  = !reset && rbeat && (owner == OWN_I);
  assign d_resp_valid  = !reset && rbeat && (owner == OWN_D);
  assign i_resp_last   = !reset && rlast && (owner == OWN_I);
  assign d_resp_last   = !reset && rlast && (owner == OWN_D);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      owner   <= OWN_I;
      write_q <= 1'b0;
      addr_q  <= '0;
      tag_q   <= '0;
      cnt     <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && any_req) begin
        owner   <= grant;
        write_q <= (grant == OWN_D) && d_req_write;
        addr_q  <= (grant == OWN_D) ? d_req_addr : i_req_addr;
        tag_q   <= (grant == OWN_D) ? d_req_tag : i_req_tag;
      end
      if (addr_done || done) begin
        cnt <= '0;
      end else if (wbeat || rbeat) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule
